// File: rtl/alu_ctrl_exec_pkg.sv
// Shared constants and types for the ALU control/execute block.
package alu_ctrl_pkg;

  // 4-bit ALU codes driven to the execute datapath
  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_ORR     = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_EOR     = 4'b0011,
    ALU_SUB     = 4'b0110,
    ALU_PASSB   = 4'b0111,
    ALU_MUL     = 4'b1000,
    ALU_ILLEGAL = 4'b1111
  } alu_code_e;

  // R-type opcodes, instruction[31:21]
  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_EOR = 11'b11001010000;
  localparam logic [10:0] OP_MUL = 11'b10011011000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_ctrl_exec_if.sv
// Request/response bundle between issue logic, the ALU block and writeback.
interface alu_ctrl_exec_if #(parameter int WIDTH = 64);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [10:0]      opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       alu_code;
  logic             zero;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, alu_op, opcode, a, b, out_ready,
    input  in_ready, out_valid, result, alu_code, zero, illegal, busy
  );

  modport slave (
    input  in_valid, alu_op, opcode, a, b, out_ready,
    output in_ready, out_valid, result, alu_code, zero, illegal, busy
  );
endinterface

// File: rtl/alu_ctrl_exec_decode.sv
// Combinational ALUOp/opcode decoder producing the 4-bit ALU code.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter bit MUL_EN = 1'b1
) (
  input  logic [1:0]  alu_op,
  input  logic [10:0] opcode,
  output alu_code_e   code,
  output logic        is_mul,
  output logic        is_illegal
);

  // alu_op 00 forces ADD, x1 forces PASSB, 10 consults the opcode table
  always_comb begin
    code = ALU_ILLEGAL;
    casez (alu_op)
      2'b00: code = ALU_ADD;
      2'b?1: code = ALU_PASSB;
      default: begin
        case (opcode)
          OP_ADD:  code = ALU_ADD;
          OP_SUB:  code = ALU_SUB;
          OP_AND:  code = ALU_AND;
          OP_ORR:  code = ALU_ORR;
          OP_EOR:  code = ALU_EOR;
          OP_MUL:  code = MUL_EN ? ALU_MUL : ALU_ILLEGAL;
          default: code = ALU_ILLEGAL;
        endcase
      end
    endcase
  end

  assign is_mul     = (code == ALU_MUL);
  assign is_illegal = (code == ALU_ILLEGAL);

endmodule

// File: rtl/alu_ctrl_exec.sv
// Execute-stage ALU: decode, single-cycle ops and iterative shift-add multiply.
module alu_ctrl_exec
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter bit MUL_EN = 1'b1
) (
  input logic            clk,
  input logic            rst,
  alu_ctrl_exec_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state, state_nxt;
  alu_code_e        code;
  logic             is_mul, is_illegal, accept;
  logic [WIDTH-1:0] alu_res, mcand, mplier, acc, acc_nxt;
  logic [CW-1:0]    cnt;

  alu_ctrl_decode #(.MUL_EN(MUL_EN)) u_dec (
    .alu_op    (bus.alu_op),
    .opcode    (bus.opcode),
    .code      (code),
    .is_mul    (is_mul),
    .is_illegal(is_illegal)
  );

  // DONE can hand off directly to the next bundle when the consumer drains
  assign bus.in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.busy      = (state == ST_MUL);

  // single-cycle result; illegal codes fall to zero
  always_comb begin
    alu_res = '0;
    case (code)
      ALU_ADD:   alu_res = bus.a + bus.b;
      ALU_SUB:   alu_res = bus.a + ~bus.b + 1'b1;
      ALU_AND:   alu_res = bus.a & bus.b;
      ALU_ORR:   alu_res = bus.a | bus.b;
      ALU_EOR:   alu_res = bus.a ^ bus.b;
      ALU_PASSB: alu_res = bus.b;
      default:   alu_res = '0;
    endcase
  end

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // next-state: accept wins in IDLE and in a draining DONE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = is_mul ? ST_MUL : ST_DONE;
      ST_MUL:  if (cnt == LAST) state_nxt = ST_DONE;
      ST_DONE: begin
        if (accept)             state_nxt = is_mul ? ST_MUL : ST_DONE;
        else if (bus.out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // datapath: capture on accept, one shift-add step per MUL cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.result   <= '0;
      bus.alu_code <= '0;
      bus.zero     <= 1'b0;
      bus.illegal  <= 1'b0;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      cnt          <= '0;
    end else if (accept) begin
      bus.alu_code <= code;
      if (is_mul) begin
        mcand  <= bus.a;
        mplier <= bus.b;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        bus.result  <= alu_res;
        bus.zero    <= (alu_res == '0);
        bus.illegal <= is_illegal;
      end
    end else if (state == ST_MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST) begin
        bus.result  <= acc_nxt;
        bus.zero    <= (acc_nxt == '0);
        bus.illegal <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Directed-vector bench for alu_ctrl_exec (MUL_EN=1 and MUL_EN=0 instances).
module tb_alu_ctrl_exec;
  import alu_ctrl_pkg::*;

  localparam int W = 64;

  logic clk, rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_ctrl_exec_if #(.WIDTH(W)) bus  ();
  alu_ctrl_exec_if #(.WIDTH(W)) bus2 ();

  alu_ctrl_exec #(.WIDTH(W), .MUL_EN(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  alu_ctrl_exec #(.WIDTH(W), .MUL_EN(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // present a bundle, let one edge accept it, then drop in_valid
  task automatic send(input logic [1:0] op, input logic [10:0] opc,
                      input logic [63:0] av, input logic [63:0] bv);
    bus.alu_op   = op;
    bus.opcode   = opc;
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int busy_bad;
    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.out_ready = 1'b1;
    bus.alu_op = '0; bus.opcode = '0; bus.a = '0; bus.b = '0;
    bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
    bus2.alu_op = '0; bus2.opcode = '0; bus2.a = '0; bus2.b = '0;
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_result",    bus.result,             64'd0);
    chk("rst_code",      {60'd0, bus.alu_code},  64'd0);
    chk("rst_zero",      {63'd0, bus.zero},      64'd0);
    chk("rst_illegal",   {63'd0, bus.illegal},   64'd0);
    chk("rst_busy",      {63'd0, bus.busy},      64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // ADD
    send(2'b10, 11'b10001011000, 64'd5, 64'd7);
    chk("add_valid",  {63'd0, bus.out_valid}, 64'd1);
    chk("add_result", bus.result,             64'd12);
    chk("add_code",   {60'd0, bus.alu_code},  64'h2);
    chk("add_zero",   {63'd0, bus.zero},      64'd0);

    // SUB wrap and SUB to zero
    send(2'b10, 11'b11001011000, 64'd3, 64'd5);
    chk("sub_wrap",   bus.result,            64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_code",   {60'd0, bus.alu_code}, 64'h6);
    send(2'b10, 11'b11001011000, 64'd9, 64'd9);
    chk("sub_zero_r", bus.result,            64'd0);
    chk("sub_zero_z", {63'd0, bus.zero},     64'd1);

    // PASSB via 01 and 11
    send(2'b01, 11'b0, 64'd77, 64'd0);
    chk("passb01_r",  bus.result,            64'd0);
    chk("passb01_z",  {63'd0, bus.zero},     64'd1);
    chk("passb01_c",  {60'd0, bus.alu_code}, 64'h7);
    send(2'b11, 11'b0, 64'd77, 64'h1234);
    chk("passb11_r",  bus.result,            64'h1234);

    // AND / EOR, then an undecodable opcode
    send(2'b10, 11'b10001010000, 64'hFF00, 64'h0FF0);
    chk("and_r",      bus.result,            64'h0F00);
    send(2'b10, 11'b11001010000, 64'hFF00, 64'h0FF0);
    chk("eor_r",      bus.result,            64'hF0F0);
    send(2'b10, 11'b11111111111, 64'd1, 64'd2);
    chk("ill_flag",   {63'd0, bus.illegal},  64'd1);
    chk("ill_r",      bus.result,            64'd0);
    chk("ill_z",      {63'd0, bus.zero},     64'd1);
    chk("ill_code",   {60'd0, bus.alu_code}, 64'hF);

    // MUL 6*7, busy for W cycles
    send(2'b10, 11'b10011011000, 64'd6, 64'd7);
    chk("mul_code",   {60'd0, bus.alu_code}, 64'h8);
    busy_bad = 0;
    for (int i = 0; i < W; i++) begin
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) busy_bad++;
      @(posedge clk); #1;
    end
    chk("mul_busy_cycles", 64'(busy_bad), 64'd0);
    chk("mul_valid",  {63'd0, bus.out_valid}, 64'd1);
    chk("mul_busy0",  {63'd0, bus.busy},      64'd0);
    chk("mul_result", bus.result,             64'd42);
    chk("mul_ill",    {63'd0, bus.illegal},   64'd0);

    // MUL with MUL_EN=0 is illegal after one edge
    bus2.alu_op = 2'b10; bus2.opcode = 11'b10011011000;
    bus2.a = 64'd6; bus2.b = 64'd7; bus2.in_valid = 1'b1;
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    chk("mul0_valid", {63'd0, bus2.out_valid}, 64'd1);
    chk("mul0_ill",   {63'd0, bus2.illegal},   64'd1);
    chk("mul0_r",     bus2.result,             64'd0);
    chk("mul0_busy",  {63'd0, bus2.busy},      64'd0);

    // back-pressure: held result ignores an offered bundle
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(2'b10, 11'b10001011000, 64'd1, 64'd1);
    bus.alu_op = 2'b10; bus.opcode = 11'b10101010000;
    bus.a = 64'hF0; bus.b = 64'h0F; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_valid",    {63'd0, bus.out_valid}, 64'd1);
      chk("bp_result",   bus.result,             64'd2);
      chk("bp_in_ready", {63'd0, bus.in_ready},  64'd0);
    end
    // release: ORR accepted on the draining edge, no IDLE gap
    bus.out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk); #1;
    chk("b2b_valid",  {63'd0, bus.out_valid}, 64'd1);
    chk("b2b_result", bus.result,             64'hFF);
    chk("b2b_code",   {60'd0, bus.alu_code},  64'h1);
    // one more back-to-back: SUB 0xFF-0xFF
    bus.opcode = 11'b11001011000; bus.a = 64'hFF; bus.b = 64'hFF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("b2b2_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("b2b2_zero",  {63'd0, bus.zero},      64'd1);

    // reset mid-MUL
    @(negedge clk);
    send(2'b10, 11'b10011011000, 64'd6, 64'd7);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
    end
    chk("rmul_busy_pre", {63'd0, bus.busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rmul_valid",  {63'd0, bus.out_valid}, 64'd0);
    chk("rmul_busy",   {63'd0, bus.busy},      64'd0);
    chk("rmul_result", bus.result,             64'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    send(2'b00, 11'b0, 64'd2, 64'd3);
    chk("post_valid",  {63'd0, bus.out_valid}, 64'd1);
    chk("post_result", bus.result,             64'd5);
    chk("post_code",   {60'd0, bus.alu_code},  64'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
